if_id_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 21 ++
 rtl/mips_instr_fields.sv | 27 ++
 rtl/if_id_stage.sv | 127 ++++++++++++
 tb/tb_if_id_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: instruction field positions, bubble encoding and
// the fetch-to-decode payload (PC+4 paired with the instruction word).
package mips_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned IMM_W     = 16;

  // sll $0,$0,0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] pc4;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/mips_instr_fields.sv
// Purely combinational MIPS32 instruction field splitter. No extension is
// applied; consumers (sign extender, register file) do their own.
module mips_instr_fields
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output logic [5:0]         o_opcode,
  output logic [4:0]         o_rs,
  output logic [4:0]         o_rt,
  output logic [4:0]         o_rd,
  output logic [4:0]         o_shamt,
  output logic [5:0]         o_funct,
  output logic [IMM_W-1:0]   o_imm16
);

  // Fixed-position slices of the instruction word
  always_comb begin
    o_opcode = i_instr[OPC_MSB -: 6];
    o_rs     = i_instr[RS_LSB +: 5];
    o_rt     = i_instr[RT_LSB +: 5];
    o_rd     = i_instr[RD_LSB +: 5];
    o_shamt  = i_instr[SHAMT_LSB +: 5];
    o_funct  = i_instr[5:0];
    o_imm16  = i_instr[IMM_W-1:0];
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid/ready handshake on both sides and a
// flush for branch/jump redirect. Holds PC+4 and the instruction for decode
// and exposes the decoded fields (out_imm16 feeds the sign extender).
// Optional: define IF_ID_SKID_EN for a one-entry skid buffer that registers
// in_ready (no combinational path from out_ready to in_ready).
module if_id_stage
  import mips_pkg::*;
#(
  parameter int unsigned          DATA_W    = 32,
  parameter logic [DATA_W-1:0]    NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc4,
  output logic [DATA_W-1:0] out_instr,
  output logic [5:0]        out_opcode,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [5:0]        out_funct,
  output logic [15:0]       out_imm16
);

  logic              r_valid;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_instr;
  logic              w_in_xfer;
  logic              w_main_free;

  assign w_in_xfer   = in_valid && in_ready;
  // Main register can take new content this edge: empty, or draining to decode
  assign w_main_free = !r_valid || out_ready;

`ifdef IF_ID_SKID_EN

  logic              r_sk_valid;
  logic [DATA_W-1:0] r_sk_pc4;
  logic [DATA_W-1:0] r_sk_instr;

  assign in_ready = !r_sk_valid;

  // Main + skid registers; skid refills main first so order is preserved
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc4      <= '0;
      r_instr    <= NOP_INSTR;
      r_sk_valid <= 1'b0;
      r_sk_pc4   <= '0;
      r_sk_instr <= NOP_INSTR;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_sk_valid <= 1'b0;
      r_sk_instr <= NOP_INSTR;
    end else if (w_main_free) begin
      if (r_sk_valid) begin
        r_valid    <= 1'b1;
        r_pc4      <= r_sk_pc4;
        r_instr    <= r_sk_instr;
        r_sk_valid <= 1'b0;
        r_sk_instr <= NOP_INSTR;
      end else if (w_in_xfer) begin
        r_valid <= 1'b1;
        r_pc4   <= in_pc4;
        r_instr <= in_instr;
      end else if (r_valid) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end
    end else if (w_in_xfer) begin
      // Main full and stalled: park the new instruction in the skid slot
      r_sk_valid <= 1'b1;
      r_sk_pc4   <= in_pc4;
      r_sk_instr <= in_instr;
    end
  end

`else

  assign in_ready = w_main_free;

  // Single register: load on input transfer, bubble on drain, hold on stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc4   <= '0;
      r_instr <= NOP_INSTR;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_pc4   <= in_pc4;
      r_instr <= in_instr;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end
  end

`endif

  assign out_valid = r_valid;
  assign out_pc4   = r_pc4;
  assign out_instr = r_instr;

  mips_instr_fields u_fields (
    .i_instr  (r_instr),
    .o_opcode (out_opcode),
    .o_rs     (out_rs),
    .o_rt     (out_rt),
    .o_rd     (out_rd),
    .o_shamt  (out_shamt),
    .o_funct  (out_funct),
    .o_imm16  (out_imm16)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage (base and IF_ID_SKID_EN builds).
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc4;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;

  int n_checks;
  int n_errors;

  if_id_stage #(
    .DATA_W    (32),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc4     (in_pc4),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc4    (out_pc4),
    .out_instr  (out_instr),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_shamt  (out_shamt),
    .out_funct  (out_funct),
    .out_imm16  (out_imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream_instr [8];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pc4    = '0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset held for two cycles
    step();
    step();
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_instr", out_instr, 32'd0);
    check_eq("rst_pc4", out_pc4, 32'd0);
    check_eq("rst_fields", {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct}, 32'd0);
    check_eq("rst_imm16", {16'd0, out_imm16}, 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Single transfer: addi $t0,$zero,-1
    in_valid  = 1'b1;
    in_instr  = 32'h2008FFFF;
    in_pc4    = 32'h00400004;
    out_ready = 1'b1;
    step();
    check_eq("x1_valid", {31'd0, out_valid}, 32'd1);
    check_eq("x1_opcode", {26'd0, out_opcode}, 32'h08);
    check_eq("x1_rs", {27'd0, out_rs}, 32'd0);
    check_eq("x1_rt", {27'd0, out_rt}, 32'd8);
    check_eq("x1_imm16", {16'd0, out_imm16}, 32'h0000FFFF);
    check_eq("x1_pc4", out_pc4, 32'h00400004);

    // Stall with a second instruction offered
    in_instr  = 32'h012A4020;
    in_pc4    = 32'h00400008;
    out_ready = 1'b0;
    #1;
`ifdef IF_ID_SKID_EN
    check_eq("stall_ready_skid", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_eq("stall_ready_full", {31'd0, in_ready}, 32'd0);
    check_eq("stall0_instr", out_instr, 32'h2008FFFF);
    step();
    step();
`else
    check_eq("stall_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_instr", out_instr, 32'h2008FFFF);
      check_eq("stall_ready", {31'd0, in_ready}, 32'd0);
    end
`endif
    check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
    check_eq("stall_pc4", out_pc4, 32'h00400004);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("drain2_instr", out_instr, 32'h012A4020);
    check_eq("drain2_pc4", out_pc4, 32'h00400008);
    check_eq("drain2_valid", {31'd0, out_valid}, 32'd1);
    check_eq("drain2_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_eq("drained_valid", {31'd0, out_valid}, 32'd0);
    check_eq("drained_instr", out_instr, 32'd0);

    // Flush while full with an input transfer in flight
    in_valid  = 1'b1;
    in_instr  = 32'h24020005;
    in_pc4    = 32'h00400010;
    out_ready = 1'b0;
    step();
    check_eq("preflush_valid", {31'd0, out_valid}, 32'd1);
    in_instr  = 32'h08100000;
    in_pc4    = 32'h00400014;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    check_eq("flush_ready", {31'd0, in_ready}, 32'd1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
    check_eq("flush_instr", out_instr, 32'd0);
    step();
    check_eq("postflush_valid", {31'd0, out_valid}, 32'd0);
    check_eq("postflush_instr", out_instr, 32'd0);

    // Back-to-back stream of eight
    stream_instr[0] = 32'h00084080;
    stream_instr[1] = 32'h2008FFFF;
    stream_instr[2] = 32'h012A4020;
    stream_instr[3] = 32'h8C880004;
    stream_instr[4] = 32'hAC880008;
    stream_instr[5] = 32'h1109FFFC;
    stream_instr[6] = 32'h3C011234;
    stream_instr[7] = 32'h03E00008;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = stream_instr[i];
      in_pc4   = 32'h00401000 + 32'(4 * (i + 1));
      step();
      check_eq("strm_valid", {31'd0, out_valid}, 32'd1);
      check_eq("strm_instr", out_instr, stream_instr[i]);
      check_eq("strm_pc4", out_pc4, 32'h00401000 + 32'(4 * (i + 1)));
      if (i == 0) begin
        check_eq("sll_shamt", {27'd0, out_shamt}, 32'd2);
        check_eq("sll_funct", {26'd0, out_funct}, 32'd0);
        check_eq("sll_rd", {27'd0, out_rd}, 32'd8);
        check_eq("sll_rt", {27'd0, out_rt}, 32'd8);
      end
    end
    in_valid = 1'b0;
    step();
    check_eq("strm_end_valid", {31'd0, out_valid}, 32'd0);

    // Reset asserted during a stall with a held instruction
    in_valid  = 1'b1;
    in_instr  = 32'h24030007;
    in_pc4    = 32'h00402000;
    out_ready = 1'b0;
    step();
    in_instr = 32'h24040009;
    in_pc4   = 32'h00402004;
    step();
    check_eq("rstall_held", out_instr, 32'h24030007);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    check_eq("rstall_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rstall_instr", out_instr, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check_eq("rstall_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rstall_stale1", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("rstall_stale2", {31'd0, out_valid}, 32'd0);
    check_eq("rstall_nop", out_instr, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
